remote_cmd_xcvr: RTL
====================

# remote_cmd_xcvr

Knight-side UART endpoint that talks to `RemoteComm`. It receives two 8N1 bytes (high byte first), assembles them into a 16-bit command, and presents the command to the command processor with a ready/clear handshake. It also serializes the 8-bit response bytes (0xA5 positive ack, 0x5A move ack) back to the remote. It sits between the `RX`/`TX` pins of `KnightsTour` and the `cmd_proc` command interface.

## Interface
- `BAUD_DIV`, 5208: clocks per bit (50 MHz / 9600 baud).
- `GAP_CLKS`, 16*5208: maximum idle clocks between the high-byte stop bit and the low-byte start bit.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `RX`  in  1  serial in from remote, asynchronous, idle high.
- `TX`  out  1  serial out to remote, idle high.
- `cmd`  out  16  last assembled command, {high byte, low byte}.
- `cmd_rdy`  out  1  new command valid; held until cleared.
- `clr_cmd_rdy`  in  1  consumer acknowledges `cmd`.
- `resp`  in  8  response byte to send.
- `send_resp`  in  1  one-cycle request to transmit `resp`.
- `resp_sent`  out  1  high after a response stop bit completes; low while transmitting.

## Operation
- **RX front end**
  - `RX` passes through a 2-flop synchronizer whose flops preset to 1.
  - A falling edge in RX idle starts reception.
  - Start bit is sampled at BAUD_DIV/2. If it reads 1, the edge was a glitch: return to idle, no byte.
  - 8 data bits are sampled LSB first, each BAUD_DIV apart, then the stop bit.
  - Stop bit = 0 is a framing error: byte discarded, assembler state unchanged except the gap timer keeps running.
- **Assembler FSM** (states WAIT_HI, WAIT_LO)
  - WAIT_HI + valid byte: latch high byte, go to WAIT_LO, clear gap counter.
  - WAIT_LO + valid byte: `cmd` <= {hi, byte}, set `cmd_rdy`, go to WAIT_HI.
  - WAIT_LO with gap counter reaching GAP_CLKS and no start bit seen: drop high byte, go to WAIT_HI. The gap counter freezes while a byte is being received.
- **cmd_rdy**
  - Cleared by `clr_cmd_rdy`, or by detection of a start edge while in WAIT_HI (a new command is starting).
  - If set and clear occur in the same cycle, set wins.
  - `cmd` changes only when `cmd_rdy` is set.
- **TX**
  - `send_resp` while idle latches `resp`, drops `resp_sent`, and sends start bit, 8 data bits LSB first, then stop bit, each BAUD_DIV clocks.
  - `send_resp` while busy is ignored; the current frame is not corrupted.
  - RX and TX run fully independently (full duplex).
- **Reset** (any cycle, including mid-frame)
  - Both FSMs return to idle.
  - `TX`=1, `cmd_rdy`=0, `cmd`=0, `resp_sent`=0.
  - A partial RX byte is lost.

## Timing
- The valid byte strobe is internal, on the clock of the stop-bit sample. `cmd_rdy` and `cmd` update on the next edge.
- `TX` falls on the clock edge after `send_resp` is sampled.
- `resp_sent` rises exactly 10*BAUD_DIV clocks after `TX` falls and stays high until the next accepted `send_resp`.
- Baud counters are ceil(log2(BAUD_DIV)) bits wide. The gap counter is ceil(log2(GAP_CLKS+1)) bits wide and saturates.
- `clr_cmd_rdy` takes effect on the next edge, giving 1-cycle latency.

## Structure
- Package `kt_uart_pkg` holds:
  - the `rx_state_t`, `tx_state_t` and `asm_state_t` enums;
  - constants `BAUD_DIV_DEF` and `POS_ACK`=8'hA5, `MOVE_ACK`=8'h5A.
- Sub-module `uart_byte_rx` contains the synchronizer, RX FSM, and byte-valid/framing logic; it is reused by the test bench models.
- TX and the assembler live in the top module.

## Test plan
- Remote sends 16'h6020 -> `cmd`=16'h6020, `cmd_rdy`=1 one clock after the second stop-bit sample. `clr_cmd_rdy` pulse -> `cmd_rdy`=0 next clock.
- `send_resp` with `resp`=8'hA5 -> `TX` waveform 0,1,0,1,0,0,1,0,1,1, each bit BAUD_DIV clocks. `resp_sent` rises at 10*BAUD_DIV. A second `send_resp` mid-frame is ignored.
- High byte 8'h60 followed by silence > GAP_CLKS, then 8'h2F and 8'h40 -> `cmd`=16'h2F40; 0x60 is never used.
- Byte with stop bit forced 0 during WAIT_LO -> no `cmd_rdy`. The next good byte completes the command with the original high byte.
- 1/4-bit low glitch on `RX` -> no byte, `cmd_rdy` unchanged.
- `rst_n`=0 for one clock mid-TX and mid-RX -> `TX`=1, `cmd_rdy`=0, `resp_sent`=0 next clock. A clean 16'h1234 afterwards is received correctly.

Source files
------------

// File: rtl/kt_uart_pkg.sv
// Shared types and constants for the knight-side UART command transceiver.
package kt_uart_pkg;

  localparam int         BAUD_DIV_DEF = 5208;   // 50 MHz / 9600 baud
  localparam logic [7:0] POS_ACK      = 8'hA5;
  localparam logic [7:0] MOVE_ACK     = 8'h5A;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic       {WAIT_HI, WAIT_LO}                    asm_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchronizer, start-bit qualification, LSB-first
// data shift and stop-bit check. Emits a one-cycle valid strobe for good
// bytes and a one-cycle pulse when a start bit is confirmed.
module uart_byte_rx
  import kt_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       start_o,
  output logic       busy_o
);

  localparam int             CW      = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(BAUD_DIV - 1);

  // [0],[1] synchronizer flops; [2] delayed copy for falling-edge detection.
  logic [2:0]    sync_q;
  rx_state_t     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          vld_q, vld_d;
  logic          start_q, start_d;
  logic          rx_s, fall;

  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~rx_s;

  // Synchronizer presets to idle-high so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], rx_i};
  end

  // RX FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      vld_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      vld_q   <= vld_d;
      start_q <= start_d;
    end
  end

  // RX next state: mid-start qualification, then one sample per bit period.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    vld_d   = 1'b0;
    start_d = 1'b0;
    case (st_q)
      RX_IDLE: if (fall) begin
        st_d  = RX_START;
        cnt_d = '0;
      end
      RX_START: if (cnt_q == HALF_M1) begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) begin
          st_d    = RX_DATA;
          start_d = 1'b1;
        end else begin
          st_d = RX_IDLE;   // line back high: glitch, not a start bit
        end
      end else cnt_d = cnt_q + CW'(1);
      RX_DATA: if (cnt_q == FULL_M1) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) st_d = RX_STOP;
      end else cnt_d = cnt_q + CW'(1);
      RX_STOP: if (cnt_q == FULL_M1) begin
        st_d  = RX_IDLE;
        vld_d = rx_s;       // stop bit low = framing error, byte dropped
      end else cnt_d = cnt_q + CW'(1);
      default: st_d = RX_IDLE;
    endcase
  end

  assign byte_o     = shift_q;
  assign byte_vld_o = vld_q;
  assign start_o    = start_q;
  assign busy_o     = (st_q != RX_IDLE);

endmodule

// File: rtl/remote_cmd_xcvr.sv
// Remote command transceiver: assembles two received bytes (high first)
// into a 16-bit command with a ready/clear handshake, and serializes
// single response bytes back to the remote. RX and TX are independent.
module remote_cmd_xcvr
  import kt_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int GAP_CLKS = 16 * BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int            CW      = $clog2(BAUD_DIV);
  localparam int            GW      = $clog2(GAP_CLKS + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CLKS);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_start, rx_busy;

  uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (RX),
    .byte_o    (rx_byte),
    .byte_vld_o(rx_vld),
    .start_o   (rx_start),
    .busy_o    (rx_busy)
  );

  // ---------------- assembler ----------------
  asm_state_t    asm_q, asm_d;
  logic [7:0]    hi_q, hi_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          rdy_q, rdy_d;

  // Assembler state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_q <= WAIT_HI;
      hi_q  <= '0;
      gap_q <= '0;
      cmd_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      asm_q <= asm_d;
      hi_q  <= hi_d;
      gap_q <= gap_d;
      cmd_q <= cmd_d;
      rdy_q <= rdy_d;
    end
  end

  // Byte pairing, inter-byte gap timeout and cmd_rdy set/clear (set wins).
  always_comb begin
    logic set_rdy;
    asm_d   = asm_q;
    hi_d    = hi_q;
    gap_d   = gap_q;
    cmd_d   = cmd_q;
    set_rdy = 1'b0;
    case (asm_q)
      WAIT_HI: if (rx_vld) begin
        hi_d  = rx_byte;
        gap_d = '0;
        asm_d = WAIT_LO;
      end
      default: begin
        if (rx_vld) begin
          cmd_d   = {hi_q, rx_byte};
          set_rdy = 1'b1;
          asm_d   = WAIT_HI;
        end else if (!rx_busy) begin
          // Timer is frozen while a byte is arriving and saturates at the limit.
          if (gap_q == GAP_MAX) asm_d = WAIT_HI;
          else                  gap_d = gap_q + GW'(1);
        end
      end
    endcase
    if (set_rdy)                                      rdy_d = 1'b1;
    else if (clr_cmd_rdy || (rx_start && asm_q == WAIT_HI)) rdy_d = 1'b0;
    else                                              rdy_d = rdy_q;
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = rdy_q;

  // ---------------- transmitter ----------------
  tx_state_t     tx_q, tx_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    tbit_q, tbit_d;
  logic [9:0]    frame_q, frame_d;
  logic          sent_q, sent_d;

  // TX state register; the frame shifter idles all-ones so TX rests high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q    <= TX_IDLE;
      tcnt_q  <= '0;
      tbit_q  <= '0;
      frame_q <= '1;
      sent_q  <= 1'b0;
    end else begin
      tx_q    <= tx_d;
      tcnt_q  <= tcnt_d;
      tbit_q  <= tbit_d;
      frame_q <= frame_d;
      sent_q  <= sent_d;
    end
  end

  // TX next state: accept only when idle, then shift one bit per period.
  always_comb begin
    tx_d    = tx_q;
    tcnt_d  = tcnt_q;
    tbit_d  = tbit_q;
    frame_d = frame_q;
    sent_d  = sent_q;
    if (tx_q == TX_IDLE) begin
      if (send_resp) begin
        frame_d = {1'b1, resp, 1'b0};
        tcnt_d  = '0;
        sent_d  = 1'b0;
        tx_d    = TX_START;
      end
    end else if (tcnt_q != FULL_M1) begin
      tcnt_d = tcnt_q + CW'(1);
    end else begin
      tcnt_d  = '0;
      frame_d = {1'b1, frame_q[9:1]};
      case (tx_q)
        TX_START: begin
          tx_d   = TX_DATA;
          tbit_d = '0;
        end
        TX_DATA: begin
          tbit_d = tbit_q + 3'd1;
          if (tbit_q == 3'd7) tx_d = TX_STOP;
        end
        default: begin
          tx_d   = TX_IDLE;
          sent_d = 1'b1;
        end
      endcase
    end
  end

  assign TX        = frame_q[0];
  assign resp_sent = sent_q;

endmodule
